lsu_dmem_bridge: RTL and testbench
==================================

// Module: lsu_dmem_bridge
// PURPOSE
//  Load/store unit between the datapath's data-memory port (DM_addr, DM_writeData,
//  DM_readEnable, DM_writeEnable, DM_readData) and a variable-latency valid/ready
//  data-memory bus. Handles RV64 byte/half/word/double sizing, lane alignment and
//  load sign-extension. Raises `stall` so the core holds its PC while an access is in flight.
// PARAMETERS
//  N               64   datapath width; only 64 is supported (8 byte lanes)
//  TIMEOUT_CYCLES  255  watchdog limit; used only when LSU_TIMEOUT_EN is defined
// PORTS
//  clk             in   1     clock, rising edge
//  reset           in   1     asynchronous, active-low reset
//  DM_addr         in   N     byte address from execute (ALU result)
//  DM_writeData    in   N     store data (rs2)
//  DM_readEnable   in   1     load request
//  DM_writeEnable  in   1     store request
//  funct3          in   3     size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
//  DM_readData     out  N     sized, extended load result, registered
//  stall           out  1     core must hold PC and control while high
//  access_err      out  1     one-cycle pulse: misaligned, illegal funct3, rd&wr together, or timeout
//  mem_req_valid   out  1     bus request valid
//  mem_req_ready   in   1     bus accepts request
//  mem_req_we      out  1     1 = write
//  mem_req_addr    out  N     {DM_addr[N-1:3],3'b0}, doubleword aligned
//  mem_req_wdata   out  N     store data replicated across lanes
//  mem_req_wstrb   out  N/8   byte-lane write strobes; 0 for reads
//  mem_rsp_valid   in   1     read data or write ack, one cycle
//  mem_rsp_rdata   in   N     read data, full doubleword
// BEHAVIOUR
//  - FSM: IDLE -> REQ -> WAIT_RSP -> DONE -> IDLE. Reset (async, low): state=IDLE,
//    all outputs 0, DM_readData=0. Reset mid-access drops mem_req_valid immediately.
//  - IDLE with rd^wr, a legal size and aligned addr: latch addr/data/funct3/we; go to REQ.
//    Aligned = addr[0]=0 for H/HU, addr[1:0]=0 for W/WU, addr[2:0]=0 for D.
//  - IDLE with illegal access (misaligned, funct3=111, funct3 1xx on a store, or rd&wr
//    both high): access_err=1 for that cycle, no bus request, no stall, stay in IDLE.
//  - stall = (IDLE & legal request) | REQ | WAIT_RSP. stall is 0 in DONE, so the core
//    advances at the DONE edge.
//  - REQ: mem_req_valid=1 and every req_* field held stable until mem_req_ready. On
//    handshake go to WAIT_RSP.
//  - WAIT_RSP: on mem_rsp_valid go to DONE. For a load, capture the extracted,
//    extended lane into DM_readData. For a store, it is an ack only.
//  - mem_rsp_valid outside WAIT_RSP is ignored; the earliest response is one cycle after
//    the handshake. A late response after reset is discarded.
//  - DONE: one cycle, then IDLE. DM_readData holds until the next load completes.
//  - Best latency (ready=1 in REQ, rsp in the next cycle): stall high 3 cycles; data valid
//    on the 4th (DONE).
//  - Lanes: off=addr[2:0]. Load: byte=rdata[8*off+:8], half=rdata[8*off+:16],
//    word=rdata[8*off+:32]. Sign-extend B/H/W, zero-extend BU/HU/WU.
//    Store: wdata={8{b}} / {4{h}} / {2{w}} / d. wstrb=(8'h01 / 8'h03 / 8'h0F / 8'hFF)<<off.
// CONFIGURATION
//  LSU_TIMEOUT_EN defined: a counter runs in REQ/WAIT_RSP and clears on state entry.
//    When it reaches TIMEOUT_CYCLES: drop valid, go to DONE, access_err pulses, and a load
//    returns 0.
//  LSU_TIMEOUT_EN undefined: no counter; the unit waits indefinitely.
// STRUCTURE
//  lsu_pkg: lsu_state_t enum {IDLE,REQ,WAIT_RSP,DONE}; funct3 size localparams; strobe base masks.
//  Sub-module lsu_align (combinational): lane extract plus extend for loads, lane replicate
//  plus wstrb for stores. The FSM, latches and watchdog stay in lsu_dmem_bridge.
// TESTING
//  1 LD addr 0x10, ready=1, rsp next cycle with rdata 0x1122334455667788 ->
//    stall 3 cycles, DM_readData=0x1122334455667788.
//  2 LB addr 0x13, rdata byte3=0x80 -> DM_readData=0xFFFFFFFFFFFFFF80. LBU -> 0x80.
//  3 SH addr 0x16, data 0xBEEF -> wstrb=0xC0, wdata=0xBEEFBEEFBEEFBEEF, we=1, stall until ack.
//  4 LW addr 0x22 -> access_err pulse, mem_req_valid stays 0, stall 0. rd&wr together -> same.
//  5 ready held low 5 cycles -> valid and addr stable all 5 cycles. reset low mid-REQ ->
//    valid=0 and stall=0 immediately, late rsp ignored.
//  6 [LSU_TIMEOUT_EN, TIMEOUT_CYCLES=8] no rsp -> DONE after 8 cycles in WAIT_RSP,
//    access_err=1, DM_readData=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, funct3 size
// encodings, byte-strobe base masks and the natural-alignment helper.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } lsu_state_t;

  // funct3 encodings; bit 2 selects zero-extension for loads.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;
  localparam logic [2:0] F3_ILLEGAL = 3'b111;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  localparam logic [7:0] STRB_B = 8'h01;
  localparam logic [7:0] STRB_H = 8'h03;
  localparam logic [7:0] STRB_W = 8'h0F;
  localparam logic [7:0] STRB_D = 8'hFF;

  function automatic logic is_aligned(input logic [2:0] off, input logic [1:0] sz);
    case (sz)
      SZ_B:    is_aligned = 1'b1;
      SZ_H:    is_aligned = (off[0] == 1'b0);
      SZ_W:    is_aligned = (off[1:0] == 2'b00);
      default: is_aligned = (off == 3'b000);
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: extracts and extends the addressed lane of a
// load doubleword, and replicates store data across lanes with byte strobes.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [2:0]  off_i,
  input  logic        we_i,
  input  logic [63:0] st_data_i,
  input  logic [63:0] rdata_i,
  output logic [63:0] ld_data_o,
  output logic [63:0] st_wdata_o,
  output logic [7:0]  wstrb_o
);

  logic [63:0] shifted;
  logic [7:0]  strb_base;

  always_comb begin
    shifted    = rdata_i >> {off_i, 3'b000};
    ld_data_o  = shifted;
    st_wdata_o = st_data_i;
    strb_base  = STRB_D;
    case (funct3_i[1:0])
      SZ_B: begin
        ld_data_o  = funct3_i[2] ? {56'b0, shifted[7:0]} : {{56{shifted[7]}}, shifted[7:0]};
        st_wdata_o = {8{st_data_i[7:0]}};
        strb_base  = STRB_B;
      end
      SZ_H: begin
        ld_data_o  = funct3_i[2] ? {48'b0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
        st_wdata_o = {4{st_data_i[15:0]}};
        strb_base  = STRB_H;
      end
      SZ_W: begin
        ld_data_o  = funct3_i[2] ? {32'b0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
        st_wdata_o = {2{st_data_i[31:0]}};
        strb_base  = STRB_W;
      end
      default: begin
        ld_data_o  = shifted;
        st_wdata_o = st_data_i;
        strb_base  = STRB_D;
      end
    endcase
    wstrb_o = we_i ? (strb_base << off_i) : 8'h00;
  end

endmodule

// File: rtl/lsu_dmem_bridge.sv
// Load/store bridge from the core's data-memory port to a valid/ready memory bus.
// Define LSU_TIMEOUT_EN to add a watchdog that aborts accesses after TIMEOUT_CYCLES.
module lsu_dmem_bridge
  import lsu_pkg::*;
#(
  parameter int N = 64
`ifdef LSU_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   DM_addr,
  input  logic [N-1:0]   DM_writeData,
  input  logic           DM_readEnable,
  input  logic           DM_writeEnable,
  input  logic [2:0]     funct3,
  output logic [N-1:0]   DM_readData,
  output logic           stall,
  output logic           access_err,
  output logic           mem_req_valid,
  input  logic           mem_req_ready,
  output logic           mem_req_we,
  output logic [N-1:0]   mem_req_addr,
  output logic [N-1:0]   mem_req_wdata,
  output logic [N/8-1:0] mem_req_wstrb,
  input  logic           mem_rsp_valid,
  input  logic [N-1:0]   mem_rsp_rdata
);

  lsu_state_t  state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic        we_q, we_d;
  logic [63:0] rdata_q, rdata_d;

  logic        req_any, size_ok, legal, illegal;
  logic        to_raw, to_fire;
  logic        err_d;
  logic [63:0] ld_data;
  logic [63:0] st_wdata;
  logic [7:0]  st_wstrb;

  assign req_any = DM_readEnable | DM_writeEnable;
  assign size_ok = (funct3 != F3_ILLEGAL) && !(DM_writeEnable && funct3[2]);
  assign legal   = (DM_readEnable ^ DM_writeEnable) && size_ok &&
                   is_aligned(DM_addr[2:0], funct3[1:0]);
  assign illegal = req_any && !legal;

  lsu_align u_align (
    .funct3_i   (f3_q),
    .off_i      (addr_q[2:0]),
    .we_i       (we_q),
    .st_data_i  (wdata_q),
    .rdata_i    (mem_rsp_rdata),
    .ld_data_o  (ld_data),
    .st_wdata_o (st_wdata),
    .wstrb_o    (st_wstrb)
  );

`ifdef LSU_TIMEOUT_EN
  localparam logic [31:0] CNT_LIM = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] cnt_q;

  // Counts cycles spent in the current busy state; any state change restarts it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (state_d != state_q) begin
      cnt_q <= '0;
    end else if (state_q == REQ || state_q == WAIT_RSP) begin
      cnt_q <= cnt_q + 32'd1;
    end else begin
      cnt_q <= '0;
    end
  end

  assign to_raw = (state_q == REQ || state_q == WAIT_RSP) && (cnt_q == CNT_LIM);
`else
  assign to_raw = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    to_fire = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (legal) begin
          state_d = REQ;
          addr_d  = DM_addr;
          wdata_d = DM_writeData;
          f3_d    = funct3;
          we_d    = DM_writeEnable;
        end else if (illegal) begin
          err_d = 1'b1;
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          state_d = WAIT_RSP;
        end else if (to_raw) begin
          to_fire = 1'b1;
        end
      end
      WAIT_RSP: begin
        if (mem_rsp_valid) begin
          state_d = DONE;
          if (!we_q) rdata_d = ld_data;
        end else if (to_raw) begin
          to_fire = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A watchdog abort completes the access with an error and a zero load result.
    if (to_fire) begin
      state_d = DONE;
      err_d   = 1'b1;
      if (!we_q) rdata_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
    end
  end

  // Combinational outputs are masked while reset is held so the core sees no stall.
  assign stall = reset & (((state_q == IDLE) && legal) ||
                          (state_q == REQ) || (state_q == WAIT_RSP));
  assign access_err    = reset & err_d;
  assign mem_req_valid = (state_q == REQ);
  assign mem_req_we    = we_q;
  assign mem_req_addr  = {addr_q[63:3], 3'b000};
  assign mem_req_wdata = st_wdata;
  assign mem_req_wstrb = st_wstrb;
  assign DM_readData   = rdata_q;

endmodule

// File: tb/tb_lsu_dmem_bridge.sv
// Directed bench for lsu_dmem_bridge: loads, stores, illegal accesses, bus
// back-pressure, reset mid-access and (with LSU_TIMEOUT_EN) the watchdog.
module tb_lsu_dmem_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] DM_addr;
  logic [63:0] DM_writeData;
  logic        DM_readEnable;
  logic        DM_writeEnable;
  logic [2:0]  funct3;
  logic [63:0] DM_readData;
  logic        stall;
  logic        access_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [63:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wstrb;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_dmem_bridge #(
    .N(64)
`ifdef LSU_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .DM_addr        (DM_addr),
    .DM_writeData   (DM_writeData),
    .DM_readEnable  (DM_readEnable),
    .DM_writeEnable (DM_writeEnable),
    .funct3         (funct3),
    .DM_readData    (DM_readData),
    .stall          (stall),
    .access_err     (access_err),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_we     (mem_req_we),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wstrb  (mem_req_wstrb),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_rdata  (mem_rsp_rdata)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  // One complete legal access; ready is withheld for rdy_wait REQ cycles and the
  // response arrives in the cycle right after the handshake.
  task automatic do_access(input logic rd, input logic wr, input logic [63:0] addr,
                           input logic [63:0] wd, input logic [2:0] f3,
                           input logic [63:0] rdata, input int rdy_wait,
                           input logic [63:0] exp_rd, input logic [7:0] exp_strb,
                           input logic [63:0] exp_wdata);
    int st;
    @(negedge clk);
    DM_addr = addr; DM_writeData = wd; funct3 = f3;
    DM_readEnable = rd; DM_writeEnable = wr;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    #1;
    st = int'(stall);
    check_eq("idle_err", 64'(access_err), 64'd0);
    check_eq("idle_valid", 64'(mem_req_valid), 64'd0);
    for (int i = 0; i <= rdy_wait; i++) begin
      @(negedge clk);
      mem_req_ready = (i == rdy_wait);
      #1;
      st += int'(stall);
      check_eq("req_valid", 64'(mem_req_valid), 64'd1);
      check_eq("req_addr", mem_req_addr, {addr[63:3], 3'b000});
      check_eq("req_we", 64'(mem_req_we), 64'(wr));
      check_eq("req_wstrb", 64'(mem_req_wstrb), 64'(exp_strb));
      check_eq("req_wdata", mem_req_wdata, exp_wdata);
    end
    @(negedge clk);
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = rdata;
    #1;
    st += int'(stall);
    check_eq("wait_valid", 64'(mem_req_valid), 64'd0);
    @(negedge clk);
    mem_rsp_valid = 1'b0; mem_rsp_rdata = 64'h0;
    #1;
    check_eq("done_stall", 64'(stall), 64'd0);
    check_eq("done_rdata", DM_readData, exp_rd);
    check_eq("stall_cycles", 64'(st), 64'(3 + rdy_wait));
    DM_readEnable = 1'b0; DM_writeEnable = 1'b0;
  endtask

  task automatic do_illegal(input logic rd, input logic wr, input logic [63:0] addr,
                            input logic [2:0] f3);
    @(negedge clk);
    DM_addr = addr; funct3 = f3; DM_readEnable = rd; DM_writeEnable = wr;
    #1;
    check_eq("ill_err", 64'(access_err), 64'd1);
    check_eq("ill_stall", 64'(stall), 64'd0);
    check_eq("ill_valid", 64'(mem_req_valid), 64'd0);
    @(negedge clk);
    DM_readEnable = 1'b0; DM_writeEnable = 1'b0;
    #1;
    check_eq("ill_after_valid", 64'(mem_req_valid), 64'd0);
    check_eq("ill_after_err", 64'(access_err), 64'd0);
  endtask

  initial begin
    reset = 1'b0;
    DM_addr = 64'h10; DM_writeData = 64'h0; funct3 = 3'b011;
    DM_readEnable = 1'b1; DM_writeEnable = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = 64'h0;
    #12;
    check_eq("rst_stall", 64'(stall), 64'd0);
    check_eq("rst_valid", 64'(mem_req_valid), 64'd0);
    check_eq("rst_err", 64'(access_err), 64'd0);
    check_eq("rst_rdata", DM_readData, 64'd0);
    check_eq("rst_wstrb", 64'(mem_req_wstrb), 64'd0);
    DM_readEnable = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Loads
    do_access(1, 0, 64'h10, 64'h0, 3'b011, 64'h1122334455667788, 0,
              64'h1122334455667788, 8'h00, 64'h0);
    do_access(1, 0, 64'h13, 64'h0, 3'b000, 64'h1122334480667788, 0,
              64'hFFFFFFFFFFFFFF80, 8'h00, 64'h0);
    do_access(1, 0, 64'h13, 64'h0, 3'b100, 64'h1122334480667788, 0,
              64'h0000000000000080, 8'h00, 64'h0);
    do_access(1, 0, 64'h16, 64'h0, 3'b001, 64'h8001334455667788, 0,
              64'hFFFFFFFFFFFF8001, 8'h00, 64'h0);
    do_access(1, 0, 64'h14, 64'h0, 3'b110, 64'hDEADBEEF00000000, 0,
              64'h00000000DEADBEEF, 8'h00, 64'h0);
    do_access(1, 0, 64'h14, 64'h0, 3'b010, 64'hDEADBEEF00000000, 0,
              64'hFFFFFFFFDEADBEEF, 8'h00, 64'h0);
    do_access(1, 0, 64'h12, 64'h0, 3'b101, 64'h000000009ABC0000, 0,
              64'h0000000000009ABC, 8'h00, 64'h0);

    // Stores: read data holds the last load result
    do_access(0, 1, 64'h16, 64'h000000000000BEEF, 3'b001, 64'h0, 0,
              64'h0000000000009ABC, 8'hC0, 64'hBEEFBEEFBEEFBEEF);
    do_access(0, 1, 64'h11, 64'h00000000123456A5, 3'b000, 64'h0, 0,
              64'h0000000000009ABC, 8'h02, 64'hA5A5A5A5A5A5A5A5);
    do_access(0, 1, 64'h1C, 64'hFFFFFFFF12345678, 3'b010, 64'h0, 0,
              64'h0000000000009ABC, 8'hF0, 64'h1234567812345678);
    do_access(0, 1, 64'h20, 64'h0123456789ABCDEF, 3'b011, 64'h0, 2,
              64'h0000000000009ABC, 8'hFF, 64'h0123456789ABCDEF);

    // Back-pressure: ready low for 5 REQ cycles
    do_access(1, 0, 64'h28, 64'h0, 3'b011, 64'hCAFEF00D12345678, 5,
              64'hCAFEF00D12345678, 8'h00, 64'h0);

    // Illegal accesses
    do_illegal(1, 0, 64'h22, 3'b010);
    do_illegal(1, 1, 64'h10, 3'b011);
    do_illegal(0, 1, 64'h10, 3'b100);
    do_illegal(1, 0, 64'h10, 3'b111);
    do_illegal(1, 0, 64'h13, 3'b001);
    do_illegal(1, 0, 64'h14, 3'b011);

    // Reset asserted while the request is pending
    @(negedge clk);
    DM_addr = 64'h30; funct3 = 3'b011; DM_readEnable = 1'b1; mem_req_ready = 1'b0;
    @(negedge clk);
    #1;
    check_eq("mid_req_valid", 64'(mem_req_valid), 64'd1);
    #1;
    reset = 1'b0;
    #1;
    check_eq("mid_rst_valid", 64'(mem_req_valid), 64'd0);
    check_eq("mid_rst_stall", 64'(stall), 64'd0);
    check_eq("mid_rst_rdata", DM_readData, 64'd0);
    DM_readEnable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'hFFFFFFFFFFFFFFFF;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1;
    check_eq("late_rsp_rdata", DM_readData, 64'd0);
    check_eq("late_rsp_stall", 64'(stall), 64'd0);
    check_eq("late_rsp_valid", 64'(mem_req_valid), 64'd0);

`ifdef LSU_TIMEOUT_EN
    do_access(1, 0, 64'h10, 64'h0, 3'b011, 64'h1122334455667788, 0,
              64'h1122334455667788, 8'h00, 64'h0);
    @(negedge clk);
    DM_addr = 64'h38; funct3 = 3'b011; DM_readEnable = 1'b1; mem_req_ready = 1'b1;
    @(negedge clk);
    #1;
    check_eq("to_req_valid", 64'(mem_req_valid), 64'd1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      mem_req_ready = 1'b0;
      #1;
      check_eq("to_wait_stall", 64'(stall), 64'd1);
      check_eq("to_wait_err", 64'(access_err), 64'd0);
    end
    @(negedge clk);
    #1;
    check_eq("to_fire_err", 64'(access_err), 64'd1);
    DM_readEnable = 1'b0;
    @(negedge clk);
    #1;
    check_eq("to_done_stall", 64'(stall), 64'd0);
    check_eq("to_done_rdata", DM_readData, 64'd0);
`endif

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
